cpx_spc_rxbuf: RTL and testbench
================================

CPX_SPC_RXBUF -- requirements
Module: cpx_spc_rxbuf

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the number of packet entries; legal values are powers of two from 2 to 16.
REQ-002 The module SHALL have input rclk, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have input reset, 1 bit: reset is synchronous and active-high.
REQ-004 The module SHALL have input se, 1 bit, and input si, 1 bit: scan controls, functionally unused.
REQ-005 The module SHALL have output so, 1 bit: scan out, tied to 0.
REQ-006 The module SHALL have input cpx_spc_data_cx3, CPX_WIDTH (145) bits: the registered CPX packet, whose bit 144 is the valid bit and bits 143:140 are the return type.
REQ-007 The module SHALL have input cpx_spc_data_rdy_cx3, 1 bit: qualifies cpx_spc_data_cx3.
REQ-008 The module SHALL have output rxbuf_pkt_vld, 1 bit: a head packet is available.
REQ-009 The module SHALL have output rxbuf_pkt, 145 bits: the head packet.
REQ-010 The module SHALL have output rxbuf_pkt_rtntype, 4 bits: rxbuf_pkt[143:140].
REQ-011 The module SHALL have input rxbuf_pkt_ack, 1 bit: the consumer pops the head packet.
REQ-012 The module SHALL have output rxbuf_credit_ret, 1 bit: a one-cycle credit pulse per dequeue.
REQ-013 The module SHALL have output rxbuf_afull, 1 bit: occupancy >= DEPTH-1.
REQ-014 The module SHALL have output rxbuf_ovfl, 1 bit: sticky overflow flag.
REQ-015 The module SHALL have output rxbuf_count, clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-016 A packet SHALL be accepted ("push") only when cpx_spc_data_rdy_cx3=1 and cpx_spc_data_cx3[144]=1; other cycles SHALL be ignored.
REQ-017 Storage SHALL be a circular buffer with write and read pointers that wrap modulo DEPTH, and rxbuf_count SHALL range over 0..DEPTH.
REQ-018 A packet pushed at edge N SHALL be visible on rxbuf_pkt with rxbuf_pkt_vld=1 after edge N (latency 1 cycle).
REQ-019 rxbuf_pkt_vld SHALL equal (rxbuf_count != 0), and rxbuf_pkt SHALL be the oldest entry, or 0 when empty.
REQ-020 Packets SHALL be dequeued in strict arrival order.
REQ-021 A pop SHALL occur at an edge where rxbuf_pkt_ack=1 and rxbuf_pkt_vld=1; rxbuf_pkt_ack while empty SHALL be ignored and SHALL produce no credit.
REQ-022 A simultaneous push and pop SHALL leave the count unchanged, including when full.
REQ-023 A push while full without a simultaneous pop SHALL drop the incoming packet, leave contents unchanged and set rxbuf_ovfl=1 from the next cycle until reset.
REQ-024 rxbuf_credit_ret SHALL be registered: it is 1 for exactly the one cycle following each pop edge.
REQ-025 rxbuf_afull SHALL be combinational from rxbuf_count.

Reset
REQ-026 While reset=1 at an edge, pointers and count SHALL clear to 0, and rxbuf_ovfl and rxbuf_credit_ret SHALL clear to 0.
REQ-027 After reset, rxbuf_pkt_vld=0, rxbuf_pkt=0 and rxbuf_afull=0.
REQ-028 Entry storage need not be reset.
REQ-029 Reset SHALL take priority over a simultaneous push or pop: the packet is lost and no credit is issued.

Configuration
REQ-030 Macro CPX_RXBUF_BYPASS_EN: when defined, with the buffer empty and a push in the current cycle, the incoming packet SHALL appear combinationally on rxbuf_pkt with rxbuf_pkt_vld=1 in the same cycle (latency 0).
REQ-031 Under CPX_RXBUF_BYPASS_EN, if rxbuf_pkt_ack=1 in that cycle, the packet SHALL NOT be written, the count SHALL remain 0, and a credit SHALL pulse the next cycle.
REQ-032 Under CPX_RXBUF_BYPASS_EN, if rxbuf_pkt_ack=0 in that cycle, the packet SHALL be written normally.
REQ-033 When CPX_RXBUF_BYPASS_EN is undefined, no bypass path SHALL exist and the latency SHALL always be 1.

Verification
REQ-034 Reset, then push packet 0x1_0000_..._00AB (bit 144 set) with no ack -> the next cycle rxbuf_pkt_vld=1, rxbuf_pkt equals the packet, rxbuf_count=1, rxbuf_credit_ret=0.
REQ-035 With DEPTH=4, push 4 packets, then push a 5th with no ack -> rxbuf_count=4, rxbuf_afull=1, rxbuf_ovfl=1, and pops return packets 1-4 in order with 4 credit pulses.
REQ-036 With the buffer full, push and ack in the same cycle -> rxbuf_count stays 4, rxbuf_ovfl stays 0, the new packet becomes the tail, and a credit pulses once.
REQ-037 Present rdy=1 with bit 144=0, and ack while empty -> rxbuf_count stays 0 and rxbuf_credit_ret stays 0.
REQ-038 Push 3 packets, then assert reset together with ack -> rxbuf_count=0, rxbuf_pkt_vld=0, no credit pulse, rxbuf_ovfl=0.
REQ-039 Defined CPX_RXBUF_BYPASS_EN, empty buffer, push plus ack in the same cycle -> rxbuf_pkt_vld=1 in that cycle, rxbuf_count stays 0, and rxbuf_credit_ret=1 the next cycle; undefined -> rxbuf_pkt_vld=0 in that cycle.

Source files
------------

// File: rtl/cpx_spc_rxbuf.sv
// CPX receive buffer: circular packet FIFO with credit return and sticky overflow.
// Optional CPX_RXBUF_BYPASS_EN adds a zero-latency path when the buffer is empty.
module cpx_spc_rxbuf #(
  parameter int DEPTH = 4
) (
  input  logic                       rclk,
  input  logic                       reset,
  input  logic                       se,
  input  logic                       si,
  output logic                       so,
  input  logic [144:0]               cpx_spc_data_cx3,
  input  logic                       cpx_spc_data_rdy_cx3,
  output logic                       rxbuf_pkt_vld,
  output logic [144:0]               rxbuf_pkt,
  output logic [3:0]                 rxbuf_pkt_rtntype,
  input  logic                       rxbuf_pkt_ack,
  output logic                       rxbuf_credit_ret,
  output logic                       rxbuf_afull,
  output logic                       rxbuf_ovfl,
  output logic [$clog2(DEPTH):0]     rxbuf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [144:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovfl;
  logic          credit;

  logic push;
  logic pop;
  logic empty;
  logic full;
  logic byp;
  logic wr_en;
  logic rd_en;

  assign so = se & si & 1'b0;

  assign push  = cpx_spc_data_rdy_cx3 & cpx_spc_data_cx3[144];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

`ifdef CPX_RXBUF_BYPASS_EN
  assign byp = push & empty;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    rxbuf_pkt = '0;
    if (!empty)
      rxbuf_pkt = mem[rd_ptr];
    else if (byp)
      rxbuf_pkt = cpx_spc_data_cx3;
  end

  assign rxbuf_pkt_vld     = !empty | byp;
  assign rxbuf_pkt_rtntype = rxbuf_pkt[143:140];
  assign pop   = rxbuf_pkt_ack & rxbuf_pkt_vld;
  assign rd_en = pop & !empty;
  // a bypassed packet consumed in the same cycle is never stored
  assign wr_en = push & !(full & !pop) & !(byp & pop);

  always_ff @(posedge rclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovfl   <= 1'b0;
      credit <= 1'b0;
    end else begin
      credit <= pop;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
      if (push & full & !pop) ovfl <= 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (!reset && wr_en) mem[wr_ptr] <= cpx_spc_data_cx3;
  end

  assign rxbuf_count      = count;
  assign rxbuf_ovfl       = ovfl;
  assign rxbuf_credit_ret = credit;
  assign rxbuf_afull      = (count >= CW'(DEPTH - 1));

endmodule

// File: tb/tb_cpx_spc_rxbuf.sv
// Directed bench for cpx_spc_rxbuf (DEPTH=4), covering default and
// CPX_RXBUF_BYPASS_EN builds.
module tb_cpx_spc_rxbuf;

  logic         rclk;
  logic         reset;
  logic         se;
  logic         si;
  logic         so;
  logic [144:0] data;
  logic         rdy;
  logic         vld;
  logic [144:0] pkt;
  logic [3:0]   rtn;
  logic         ack;
  logic         credit;
  logic         afull;
  logic         ovfl;
  logic [2:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  cpx_spc_rxbuf #(.DEPTH(4)) dut (
    .rclk                 (rclk),
    .reset                (reset),
    .se                   (se),
    .si                   (si),
    .so                   (so),
    .cpx_spc_data_cx3     (data),
    .cpx_spc_data_rdy_cx3 (rdy),
    .rxbuf_pkt_vld        (vld),
    .rxbuf_pkt            (pkt),
    .rxbuf_pkt_rtntype    (rtn),
    .rxbuf_pkt_ack        (ack),
    .rxbuf_credit_ret     (credit),
    .rxbuf_afull          (afull),
    .rxbuf_ovfl           (ovfl),
    .rxbuf_count          (count)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [144:0] mk(input int n);
    logic [144:0] p;
    p = '0;
    p[144] = 1'b1;
    p[143:140] = n[3:0];
    p[7:0] = n[7:0];
    return p;
  endfunction

  task automatic cycle();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; rdy = 1'b0; ack = 1'b0; data = '0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic push_n(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      data = mk(first + i); rdy = 1'b1;
      cycle();
    end
    rdy = 1'b0; data = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", count); end
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL rst_vld got %b want 0", vld); end
    n_cmp++; if (pkt !== '0) begin n_bad++; $display("FAIL rst_pkt got %h want 0", pkt); end
    n_cmp++; if (afull !== 1'b0) begin n_bad++; $display("FAIL rst_afull got %b want 0", afull); end
    n_cmp++; if (ovfl !== 1'b0) begin n_bad++; $display("FAIL rst_ovfl got %b want 0", ovfl); end
    n_cmp++; if (credit !== 1'b0) begin n_bad++; $display("FAIL rst_credit got %b want 0", credit); end
    n_cmp++; if (so !== 1'b0) begin n_bad++; $display("FAIL so got %b want 0", so); end
  endtask

  task automatic test_single();
    logic [144:0] p;
    p = '0; p[144] = 1'b1; p[7:0] = 8'hAB;
    data = p; rdy = 1'b1; ack = 1'b0;
    cycle();
    rdy = 1'b0; data = '0;
    n_cmp++; if (vld !== 1'b1) begin n_bad++; $display("FAIL single_vld got %b want 1", vld); end
    n_cmp++; if (pkt !== p) begin n_bad++; $display("FAIL single_pkt got %h want %h", pkt, p); end
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", count); end
    n_cmp++; if (credit !== 1'b0) begin n_bad++; $display("FAIL single_credit got %b want 0", credit); end
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL single_pop_count got %0d want 0", count); end
    n_cmp++; if (credit !== 1'b1) begin n_bad++; $display("FAIL single_pop_credit got %b want 1", credit); end
    n_cmp++; if (pkt !== '0) begin n_bad++; $display("FAIL single_empty_pkt got %h want 0", pkt); end
    cycle();
    n_cmp++; if (credit !== 1'b0) begin n_bad++; $display("FAIL single_credit_end got %b want 0", credit); end
  endtask

  task automatic test_overflow();
    do_reset();
    push_n(1, 2);
    n_cmp++; if (afull !== 1'b0) begin n_bad++; $display("FAIL ov_afull2 got %b want 0", afull); end
    push_n(3, 1);
    n_cmp++; if (afull !== 1'b1) begin n_bad++; $display("FAIL ov_afull3 got %b want 1", afull); end
    push_n(4, 1);
    n_cmp++; if (ovfl !== 1'b0) begin n_bad++; $display("FAIL ov_pre got %b want 0", ovfl); end
    push_n(5, 1);
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL ov_count got %0d want 4", count); end
    n_cmp++; if (afull !== 1'b1) begin n_bad++; $display("FAIL ov_afull got %b want 1", afull); end
    n_cmp++; if (ovfl !== 1'b1) begin n_bad++; $display("FAIL ov_flag got %b want 1", ovfl); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (pkt !== mk(i)) begin n_bad++; $display("FAIL ov_order%0d got %h want %h", i, pkt, mk(i)); end
      n_cmp++; if (rtn !== 4'(i)) begin n_bad++; $display("FAIL ov_rtn%0d got %h want %h", i, rtn, 4'(i)); end
      ack = 1'b1;
      cycle();
      ack = 1'b0;
      n_cmp++; if (credit !== 1'b1) begin n_bad++; $display("FAIL ov_credit%0d got %b want 1", i, credit); end
      n_cmp++; if (count !== 3'(4 - i)) begin n_bad++; $display("FAIL ov_cnt%0d got %0d want %0d", i, count, 4 - i); end
    end
    cycle();
    n_cmp++; if (credit !== 1'b0) begin n_bad++; $display("FAIL ov_credit_end got %b want 0", credit); end
    n_cmp++; if (ovfl !== 1'b1) begin n_bad++; $display("FAIL ov_sticky got %b want 1", ovfl); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    push_n(1, 4);
    data = mk(9); rdy = 1'b1; ack = 1'b1;
    cycle();
    rdy = 1'b0; ack = 1'b0; data = '0;
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fpp_count got %0d want 4", count); end
    n_cmp++; if (ovfl !== 1'b0) begin n_bad++; $display("FAIL fpp_ovfl got %b want 0", ovfl); end
    n_cmp++; if (credit !== 1'b1) begin n_bad++; $display("FAIL fpp_credit got %b want 1", credit); end
    n_cmp++; if (pkt !== mk(2)) begin n_bad++; $display("FAIL fpp_head got %h want %h", pkt, mk(2)); end
    cycle();
    n_cmp++; if (credit !== 1'b0) begin n_bad++; $display("FAIL fpp_credit_once got %b want 0", credit); end
    ack = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    ack = 1'b0;
    n_cmp++; if (pkt !== mk(9)) begin n_bad++; $display("FAIL fpp_tail got %h want %h", pkt, mk(9)); end
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL fpp_tail_cnt got %0d want 1", count); end
  endtask

  task automatic test_ignored();
    do_reset();
    data = mk(6); data[144] = 1'b0; rdy = 1'b1; ack = 1'b1;
    cycle();
    rdy = 1'b0; data = '0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL ign_count got %0d want 0", count); end
    n_cmp++; if (credit !== 1'b0) begin n_bad++; $display("FAIL ign_credit got %b want 0", credit); end
    cycle();
    ack = 1'b0;
    n_cmp++; if (credit !== 1'b0) begin n_bad++; $display("FAIL ign_credit2 got %b want 0", credit); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    push_n(1, 5);
    n_cmp++; if (ovfl !== 1'b1) begin n_bad++; $display("FAIL rp_ovfl_set got %b want 1", ovfl); end
    reset = 1'b1; ack = 1'b1; data = mk(8); rdy = 1'b1;
    cycle();
    reset = 1'b0; ack = 1'b0; rdy = 1'b0; data = '0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rp_count got %0d want 0", count); end
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL rp_vld got %b want 0", vld); end
    n_cmp++; if (credit !== 1'b0) begin n_bad++; $display("FAIL rp_credit got %b want 0", credit); end
    n_cmp++; if (ovfl !== 1'b0) begin n_bad++; $display("FAIL rp_ovfl got %b want 0", ovfl); end
    cycle();
    n_cmp++; if (credit !== 1'b0) begin n_bad++; $display("FAIL rp_credit2 got %b want 0", credit); end
  endtask

  task automatic test_bypass();
    logic e_vld;
    logic [2:0] e_cnt;
    logic e_cr;
`ifdef CPX_RXBUF_BYPASS_EN
    e_vld = 1'b1; e_cnt = 3'd0; e_cr = 1'b1;
`else
    e_vld = 1'b0; e_cnt = 3'd1; e_cr = 1'b0;
`endif
    do_reset();
    data = mk(7); rdy = 1'b1; ack = 1'b1;
    #1;
    n_cmp++; if (vld !== e_vld) begin n_bad++; $display("FAIL byp_vld got %b want %b", vld, e_vld); end
    cycle();
    rdy = 1'b0; ack = 1'b0; data = '0;
    n_cmp++; if (count !== e_cnt) begin n_bad++; $display("FAIL byp_count got %0d want %0d", count, e_cnt); end
    n_cmp++; if (credit !== e_cr) begin n_bad++; $display("FAIL byp_credit got %b want %b", credit, e_cr); end
  endtask

  initial begin
    reset = 1'b1; se = 1'b0; si = 1'b0;
    data = '0; rdy = 1'b0; ack = 1'b0;
    #2;
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_ignored();
    test_reset_priority();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
